// File: rtl/bip_control_unit_if.sv
// Control bus between the BIP sequencer and the datapath, program counter and data memory.
// The master side is the control unit, which takes in the instruction and drives every strobe.
interface bip_control_unit_if #(
    parameter int AB  = 11,
    parameter int OPW = 5
);
    logic [OPW+AB-1:0] instr;
    logic              acc_zero;
    logic              pc_inc;
    logic              WrPC;
    logic [AB-1:0]     address_bus;
    logic [AB-1:0]     operand;
    logic [1:0]        SelA;
    logic              SelB;
    logic              WrAcc;
    logic              Op;
    logic              WrRam;
    logic              RdRam;

    modport master (
        input  instr, acc_zero,
        output pc_inc, WrPC, address_bus, operand,
               SelA, SelB, WrAcc, Op, WrRam, RdRam
    );

    modport slave (
        output instr, acc_zero,
        input  pc_inc, WrPC, address_bus, operand,
               SelA, SelB, WrAcc, Op, WrRam, RdRam
    );
endinterface

// File: rtl/bip_control_unit.sv
// BIP fetch/decode sequencer: a two-cycle FETCH/EXEC loop that decodes the instruction word into controls.
// It stops for good on HLT and counts the clock cycles spent running.
module bip_control_unit #(
    parameter int AB  = 11,
    parameter int OPW = 5,
    parameter int CW  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_bip,
    bip_control_unit_if.master  bus,
    output logic                halted,
    output logic [CW-1:0]       cycle_count
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    localparam logic [OPW-1:0] OP_HLT  = OPW'(0);
    localparam logic [OPW-1:0] OP_STO  = OPW'(1);
    localparam logic [OPW-1:0] OP_LD   = OPW'(2);
    localparam logic [OPW-1:0] OP_LDI  = OPW'(3);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(4);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(5);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(6);
    localparam logic [OPW-1:0] OP_SUBI = OPW'(7);
    localparam logic [OPW-1:0] OP_JMP  = OPW'(8);
    localparam logic [OPW-1:0] OP_BEQZ = OPW'(9);

    state_t         state;
    state_t         next_state;
    logic [OPW-1:0] opcode;

    assign opcode          = bus.instr[OPW+AB-1:AB];
    assign bus.operand     = bus.instr[AB-1:0];
    assign bus.address_bus = bus.instr[AB-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The strobes come straight out of this decode, so an asynchronous reset drops them at once.
    always_comb begin
        next_state = state;
        bus.pc_inc = 1'b0;
        bus.WrPC   = 1'b0;
        bus.SelA   = 2'd0;
        bus.SelB   = 1'b0;
        bus.WrAcc  = 1'b0;
        bus.Op     = 1'b0;
        bus.WrRam  = 1'b0;
        bus.RdRam  = 1'b0;
        case (state)
            IDLE: begin
                if (start_bip) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                next_state = EXEC;
            end
            EXEC: begin
                next_state = FETCH;
                case (opcode)
                    OP_HLT: begin
                        next_state = HALT;
                    end
                    OP_STO: begin
                        bus.WrRam  = 1'b1;
                        bus.pc_inc = 1'b1;
                    end
                    OP_LD: begin
                        bus.RdRam  = 1'b1;
                        bus.WrAcc  = 1'b1;
                        bus.pc_inc = 1'b1;
                    end
                    OP_LDI: begin
                        bus.SelA   = 2'd1;
                        bus.WrAcc  = 1'b1;
                        bus.pc_inc = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        bus.RdRam  = 1'b1;
                        bus.SelA   = 2'd2;
                        bus.Op     = (opcode == OP_SUB);
                        bus.WrAcc  = 1'b1;
                        bus.pc_inc = 1'b1;
                    end
                    OP_ADDI, OP_SUBI: begin
                        bus.SelB   = 1'b1;
                        bus.SelA   = 2'd2;
                        bus.Op     = (opcode == OP_SUBI);
                        bus.WrAcc  = 1'b1;
                        bus.pc_inc = 1'b1;
                    end
                    OP_JMP: begin
                        bus.WrPC = 1'b1;
                    end
                    OP_BEQZ: begin
                        bus.WrPC   = bus.acc_zero;
                        bus.pc_inc = ~bus.acc_zero;
                    end
                    default: begin
                        bus.pc_inc = 1'b1;
                    end
                endcase
            end
            HALT: begin
                next_state = HALT;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted <= 1'b0;
        end else if (state == EXEC && opcode == OP_HLT) begin
            halted <= 1'b1;
        end
    end

    // The counter saturates instead of wrapping, so a very long run still reads as "at least this many".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= '0;
        end else if ((state == FETCH || state == EXEC) && cycle_count != {CW{1'b1}}) begin
            cycle_count <= cycle_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_bip_control_unit.sv
// Directed bench for bip_control_unit: it plays short programs one instruction at a time and checks
// each decode against a control vector worked out by hand.
module tb_bip_control_unit;
    localparam int AB  = 11;
    localparam int OPW = 5;
    localparam int CW  = 32;

    logic          clk;
    logic          rst_n;
    logic          start_bip;
    logic          halted;
    logic [CW-1:0] cycle_count;
    logic [8:0]    ctrl_obs;
    int            check_count;
    int            error_count;

    bip_control_unit_if #(.AB(AB), .OPW(OPW)) bus ();

    bip_control_unit #(.AB(AB), .OPW(OPW), .CW(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_bip   (start_bip),
        .bus         (bus),
        .halted      (halted),
        .cycle_count (cycle_count)
    );

    // Control vector layout: {pc_inc, WrPC, WrAcc, WrRam, RdRam, SelA[1:0], SelB, Op}
    assign ctrl_obs = {bus.pc_inc, bus.WrPC, bus.WrAcc, bus.WrRam, bus.RdRam,
                       bus.SelA, bus.SelB, bus.Op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic doReset();
        rst_n     = 1'b0;
        start_bip = 1'b0;
        bus.instr    = '0;
        bus.acc_zero = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a negedge while IDLE; returns at the negedge of the first FETCH cycle.
    task automatic startRun();
        start_bip = 1'b1;
        @(negedge clk);
        start_bip = 1'b0;
    endtask

    // Called at a negedge during FETCH; returns at the negedge of the cycle after EXEC.
    task automatic applyStimulus(input string tag, input logic [4:0] op, input logic [10:0] arg,
                                 input logic az, input logic [8:0] exp_ctrl);
        bus.instr    = {op, arg};
        bus.acc_zero = az;
        checkOutput({tag, "_fetch"}, 32'(ctrl_obs), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_exec"}, 32'(ctrl_obs), 32'(exp_ctrl));
        checkOutput({tag, "_addr"}, 32'(bus.address_bus), 32'(arg));
        checkOutput({tag, "_opnd"}, 32'(bus.operand), 32'(arg));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        check_count = 0;
        error_count = 0;

        // Reset, then idle with start_bip low
        doReset();
        checkOutput("rst_ctrl", 32'(ctrl_obs), 32'd0);
        checkOutput("rst_count", cycle_count, 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        repeat (10) @(negedge clk);
        checkOutput("idle_ctrl", 32'(ctrl_obs), 32'd0);
        checkOutput("idle_count", cycle_count, 32'd0);
        checkOutput("idle_halted", 32'(halted), 32'd0);

        // Straight-line program: LDI 5, ADDI 3, STO 7, HLT
        startRun();
        applyStimulus("ldi",  5'b00011, 11'd5, 1'b0, 9'b1_0_1_0_0_01_0_0);
        checkOutput("ldi_count", cycle_count, 32'd2);
        applyStimulus("addi", 5'b00101, 11'd3, 1'b0, 9'b1_0_1_0_0_10_1_0);
        applyStimulus("sto",  5'b00001, 11'd7, 1'b0, 9'b1_0_0_1_0_00_0_0);
        checkOutput("sto_halted", 32'(halted), 32'd0);
        applyStimulus("hlt",  5'b00000, 11'd0, 1'b0, 9'b0);
        checkOutput("hlt_halted", 32'(halted), 32'd1);
        checkOutput("hlt_count", cycle_count, 32'd8);

        // start_bip and a live opcode are both ignored once halted
        bus.instr = {5'b00011, 11'd9};
        start_bip = 1'b1;
        repeat (3) @(negedge clk);
        start_bip = 1'b0;
        @(negedge clk);
        checkOutput("halt_ctrl", 32'(ctrl_obs), 32'd0);
        checkOutput("halt_count", cycle_count, 32'd8);
        checkOutput("halt_halted", 32'(halted), 32'd1);

        // Remaining opcodes, branches and an undefined opcode
        doReset();
        startRun();
        applyStimulus("ld",     5'b00010, 11'h04A, 1'b0, 9'b1_0_1_0_1_00_0_0);
        applyStimulus("add",    5'b00100, 11'h001, 1'b0, 9'b1_0_1_0_1_10_0_0);
        applyStimulus("sub",    5'b00110, 11'h002, 1'b0, 9'b1_0_1_0_1_10_0_1);
        applyStimulus("subi",   5'b00111, 11'h7FF, 1'b0, 9'b1_0_1_0_0_10_1_1);
        applyStimulus("jmp",    5'b01000, 11'h123, 1'b0, 9'b0_1_0_0_0_00_0_0);
        applyStimulus("beqz_z", 5'b01001, 11'h010, 1'b1, 9'b0_1_0_0_0_00_0_0);
        applyStimulus("beqz_n", 5'b01001, 11'h010, 1'b0, 9'b1_0_0_0_0_00_0_0);
        applyStimulus("nop",    5'b11111, 11'h2AA, 1'b1, 9'b1_0_0_0_0_00_0_0);
        applyStimulus("undef",  5'b01010, 11'h000, 1'b0, 9'b1_0_0_0_0_00_0_0);
        checkOutput("run_halted", 32'(halted), 32'd0);
        applyStimulus("hlt2",   5'b00000, 11'h555, 1'b1, 9'b0);
        checkOutput("run_count", cycle_count, 32'd20);
        checkOutput("run_halted2", 32'(halted), 32'd1);

        // Reset dropped in the middle of an ADD's EXEC cycle
        doReset();
        startRun();
        bus.instr    = {5'b00100, 11'h055};
        bus.acc_zero = 1'b0;
        @(negedge clk);
        checkOutput("mid_wracc_pre", 32'(bus.WrAcc), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_wracc_async", 32'(bus.WrAcc), 32'd0);
        checkOutput("mid_ctrl_async", 32'(ctrl_obs), 32'd0);
        checkOutput("mid_count_async", cycle_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("post_ctrl", 32'(ctrl_obs), 32'd0);
        checkOutput("post_count", cycle_count, 32'd0);
        checkOutput("post_halted", 32'(halted), 32'd0);

        // Still IDLE: a fresh start counts from zero again
        startRun();
        applyStimulus("post_ldi", 5'b00011, 11'd1, 1'b0, 9'b1_0_1_0_0_01_0_0);
        checkOutput("post_ldi_count", cycle_count, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end
endmodule
